// File: rtl/core_pkg.sv
// Shared FPU core definitions: operand RAM geometry and the memory controller state set.
package core_pkg;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        READY,
        RD_A,
        RD_B,
        CAP,
        PRESENT,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/core_mem_ctrl.sv
// Operand memory controller: streams operands into the external operand RAM,
// then reads them back pairwise on request from core_control.
module core_mem_ctrl
    import core_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                mc_clk,
    input  logic                mc_reset,
    input  logic                mc_start,
    input  logic [DATA_W-1:0]   mc_data_in,
    input  logic                mc_data_valid,
    input  logic                mc_data_last,
    output logic                mc_data_ready,
    output logic [ADDR_W-1:0]   mc_data_address_out,
    output logic                mc_we,
    output logic [DATA_W-1:0]   mc_wdata,
    input  logic [DATA_W-1:0]   mc_rdata,
    output logic [ADDR_W:0]     mc_data_length,
    output logic                mc_data_done,
    input  logic                mc_cont_procc,
    output logic [DATA_W-1:0]   mc_op_a,
    output logic [DATA_W-1:0]   mc_op_b,
    output logic                mc_op_valid,
    output logic                mc_done,
    output logic                mc_err
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    state_t          state;
    logic [ADDR_W:0] wr_cnt;
    logic [ADDR_W:0] rd_ptr;

    // A start pulse wins over a concurrent word, so ready is masked that cycle.
    assign mc_data_ready  = (state == LOAD) && !mc_start;
    assign mc_data_length = wr_cnt;

    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state               <= IDLE;
            wr_cnt              <= '0;
            rd_ptr              <= '0;
            mc_data_address_out <= '0;
            mc_we               <= 1'b0;
            mc_wdata            <= '0;
            mc_data_done        <= 1'b0;
            mc_op_a             <= '0;
            mc_op_b             <= '0;
            mc_op_valid         <= 1'b0;
            mc_done             <= 1'b0;
            mc_err              <= 1'b0;
        end else begin
            mc_we       <= 1'b0;
            mc_op_valid <= 1'b0;
            if (mc_start) begin
                wr_cnt       <= '0;
                rd_ptr       <= '0;
                mc_data_done <= 1'b0;
                mc_done      <= 1'b0;
                mc_err       <= 1'b0;
                state        <= LOAD;
            end else begin
                case (state)
                    LOAD: begin
                        if (mc_data_valid) begin
                            if (wr_cnt == FULL) begin
                                mc_err <= 1'b1;
                                state  <= ERR;
                            end else begin
                                mc_we               <= 1'b1;
                                mc_data_address_out <= wr_cnt[ADDR_W-1:0];
                                mc_wdata            <= mc_data_in;
                                wr_cnt              <= wr_cnt + 1'b1;
                                if (mc_data_last) begin
                                    // Current count even means the new total is odd.
                                    if (!wr_cnt[0]) begin
                                        mc_err <= 1'b1;
                                        state  <= ERR;
                                    end else begin
                                        mc_data_done <= 1'b1;
                                        state        <= READY;
                                    end
                                end
                            end
                        end
                    end
                    READY: begin
                        if (mc_cont_procc) begin
                            mc_data_address_out <= rd_ptr[ADDR_W-1:0];
                            state               <= RD_A;
                        end
                    end
                    RD_A: begin
                        mc_data_address_out <= rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
                        state               <= RD_B;
                    end
                    RD_B: begin
                        mc_op_a <= mc_rdata;
                        state   <= CAP;
                    end
                    CAP: begin
                        mc_op_b     <= mc_rdata;
                        rd_ptr      <= rd_ptr + (ADDR_W + 1)'(2);
                        mc_op_valid <= 1'b1;
                        state       <= PRESENT;
                    end
                    PRESENT: begin
                        if (rd_ptr == wr_cnt) begin
                            mc_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= READY;
                        end
                    end
                    IDLE, DONE, ERR: state <= state;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_core_mem_ctrl.sv
// Scoreboard bench for core_mem_ctrl: stimulus pushes expected RAM writes and operand
// pairs into queues, a negedge monitor pops and compares whenever the DUT presents them.
module tb_core_mem_ctrl;
    import core_pkg::*;

    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mc_start, mc_data_valid, mc_data_last, mc_cont_procc;
    logic [DW-1:0]     mc_data_in, mc_rdata, mc_wdata, mc_op_a, mc_op_b;
    logic              mc_data_ready, mc_we, mc_data_done, mc_op_valid, mc_done, mc_err;
    logic [ADDR_W-1:0] mc_addr;
    logic [ADDR_W:0]   mc_data_length;

    core_mem_ctrl #(.DATA_W(DW)) dut (
        .mc_clk(clk), .mc_reset(rst), .mc_start(mc_start),
        .mc_data_in(mc_data_in), .mc_data_valid(mc_data_valid), .mc_data_last(mc_data_last),
        .mc_data_ready(mc_data_ready), .mc_data_address_out(mc_addr), .mc_we(mc_we),
        .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_data_length(mc_data_length),
        .mc_data_done(mc_data_done), .mc_cont_procc(mc_cont_procc), .mc_op_a(mc_op_a),
        .mc_op_b(mc_op_b), .mc_op_valid(mc_op_valid), .mc_done(mc_done), .mc_err(mc_err)
    );

    always #5 clk = ~clk;

    // External synchronous operand RAM
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mc_we) ram[mc_addr] <= mc_wdata;
        mc_rdata <= ram[mc_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { int cyc; logic [DW-1:0] a; logic [DW-1:0] b; } pr_t;
    wr_t wq[$];
    pr_t pq[$];
    logic [DW-1:0] data_q[$];

    logic [DW-1:0] ref_mem [DEPTH];
    int m_cnt = 0;
    int m_rd  = 0;
    int checks = 0;
    int failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        wr_t w;
        pr_t p;
        if (mc_we) begin
            if (wq.size() == 0) chk("we_unexpected", 64'd1, 64'd0);
            else begin
                w = wq.pop_front();
                chk("we_addr", 64'(mc_addr), 64'(w.addr));
                chk("we_data", 64'(mc_wdata), 64'(w.data));
                chk("we_cycle", 64'(cyc), 64'(w.cyc));
                $display("write addr=%0d data=%08h cycle=%0d", mc_addr, mc_wdata, cyc);
            end
        end
        if (mc_op_valid) begin
            if (pq.size() == 0) chk("opv_unexpected", 64'd1, 64'd0);
            else begin
                p = pq.pop_front();
                chk("op_a", 64'(mc_op_a), 64'(p.a));
                chk("op_b", 64'(mc_op_b), 64'(p.b));
                chk("op_cycle", 64'(cyc), 64'(p.cyc));
                $display("pair a=%08h b=%08h cycle=%0d", mc_op_a, mc_op_b, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        mc_start = 1'b1;
        step();
        mc_start = 1'b0;
        m_cnt = 0;
        m_rd  = 0;
    endtask

    task automatic load_words(int n, bit last_final, bit gaps);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                mc_data_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            d = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
            mc_data_valid = 1'b1;
            mc_data_in    = d;
            mc_data_last  = last_final && (i == n - 1);
            @(negedge clk);
            chk("ready_load", 64'(mc_data_ready), 64'd1);
            wq.push_back('{cyc + 1, ADDR_W'(m_cnt), d});
            ref_mem[m_cnt] = d;
            m_cnt++;
            step();
        end
        mc_data_valid = 1'b0;
        mc_data_last  = 1'b0;
    endtask

    task automatic req_pair();
        bit got = 0;
        mc_cont_procc = 1'b1;
        pq.push_back('{cyc + 4, ref_mem[m_rd], ref_mem[m_rd + 1]});
        m_rd += 2;
        step();
        mc_cont_procc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mc_op_valid) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("opv_timeout", 64'd0, 64'd1);
        step();
        chk("done_after_pair", 64'(mc_done), (m_rd == m_cnt) ? 64'd1 : 64'd0);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_ready"}, 64'(mc_data_ready), 64'd0);
        chk({tag, "_addr"}, 64'(mc_addr), 64'd0);
        chk({tag, "_we"}, 64'(mc_we), 64'd0);
        chk({tag, "_wdata"}, 64'(mc_wdata), 64'd0);
        chk({tag, "_len"}, 64'(mc_data_length), 64'd0);
        chk({tag, "_ddone"}, 64'(mc_data_done), 64'd0);
        chk({tag, "_opa"}, 64'(mc_op_a), 64'd0);
        chk({tag, "_opb"}, 64'(mc_op_b), 64'd0);
        chk({tag, "_opv"}, 64'(mc_op_valid), 64'd0);
        chk({tag, "_done"}, 64'(mc_done), 64'd0);
        chk({tag, "_err"}, 64'(mc_err), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        mc_start = 1'b0; mc_data_valid = 1'b0; mc_data_last = 1'b0;
        mc_cont_procc = 1'b0; mc_data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        step();

        // Directed four-word load and two pairs
        data_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        do_start();
        load_words(4, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_ready_fall", 64'(mc_data_ready), 64'd0);
        chk("t1_data_done", 64'(mc_data_done), 64'd1);
        chk("t1_length", 64'(mc_data_length), 64'd4);
        step();
        req_pair();
        req_pair();

        // Odd-length stream
        do_start();
        load_words(3, 1'b1, 1'b1);
        @(negedge clk);
        chk("odd_err", 64'(mc_err), 64'd1);
        chk("odd_data_done", 64'(mc_data_done), 64'd0);
        step();
        mc_cont_procc = 1'b1;
        step();
        mc_cont_procc = 1'b0;
        repeat (6) step();
        do_start();
        @(negedge clk);
        chk("start_clears_err", 64'(mc_err), 64'd0);
        step();

        // Overflow: 64 words then one extra
        load_words(64, 1'b0, 1'b0);
        mc_data_valid = 1'b1;
        mc_data_in = $urandom;
        @(negedge clk);
        chk("ovf_ready", 64'(mc_data_ready), 64'd1);
        step();
        mc_data_valid = 1'b0;
        @(negedge clk);
        chk("ovf_err", 64'(mc_err), 64'd1);
        chk("ovf_length", 64'(mc_data_length), 64'd64);
        chk("ovf_data_done", 64'(mc_data_done), 64'd0);
        repeat (3) step();

        // Reset in the middle of a read
        do_start();
        load_words(4, 1'b1, 1'b0);
        step();
        mc_cont_procc = 1'b1;
        step();
        mc_cont_procc = 1'b0;
        step();
        #1 rst = 1'b1;
        #1 check_zero("rst_rdb");
        step();
        rst = 1'b0;
        repeat (8) step();
        do_start();
        load_words(6, 1'b1, 1'b1);
        @(negedge clk);
        chk("post_rst_length", 64'(mc_data_length), 64'd6);
        step();
        repeat (3) req_pair();

        // Request during LOAD, then start concurrent with a valid word
        do_start();
        load_words(2, 1'b0, 1'b0);
        mc_cont_procc = 1'b1;
        step();
        mc_cont_procc = 1'b0;
        mc_start = 1'b1;
        mc_data_valid = 1'b1;
        mc_data_in = $urandom;
        @(negedge clk);
        chk("concurrent_ready", 64'(mc_data_ready), 64'd0);
        step();
        mc_start = 1'b0;
        mc_data_valid = 1'b0;
        m_cnt = 0;
        m_rd = 0;
        @(negedge clk);
        chk("concurrent_length", 64'(mc_data_length), 64'd0);
        step();
        load_words(2, 1'b1, 1'b0);
        @(negedge clk);
        chk("concurrent_done", 64'(mc_data_done), 64'd1);
        step();
        req_pair();

        // Randomized even-length loads and full readback
        repeat (6) begin
            n = 2 * $urandom_range(1, 12);
            do_start();
            load_words(n, 1'b1, 1'b1);
            @(negedge clk);
            chk("rnd_length", 64'(mc_data_length), 64'(n));
            chk("rnd_data_done", 64'(mc_data_done), 64'd1);
            step();
            while (m_rd < m_cnt) begin
                repeat ($urandom_range(0, 3)) step();
                req_pair();
            end
        end

        repeat (3) step();
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("pq_empty", 64'(pq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
